data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-through, write-allocate L1 data cache for one pipeline lane.
//  - Upstream side: serves MEM-stage lw/sw.
//  - Downstream side: issues block reads and word write-throughs to data memory, which
//    returns a full BLOCK_SIZE-word block after a multi-cycle delay with one-cycle ready pulses.
//  - Stalls the pipeline for the whole miss/write-through duration.
// PARAMETERS
//  SETS        8   number of cache lines (power of 2)
//  INDEX_BITS  3   log2(SETS)
//  BLOCK_SIZE  4   words per line; offset = Addr[3:2], tag = Addr[31:4+INDEX_BITS]
// PORTS
//  Clk             in   1                  clock, rising edge
//  Rst             in   1                  asynchronous, active-high reset
//  MemRead         in   1                  lw request from MEM stage
//  MemWrite        in   1                  sw request; wins if both MemRead and MemWrite are high
//  Addr            in   32                 byte address; Addr[1:0] ignored
//  WriteData       in   32                 sw store data
//  ReadData        out  32                 lw result; valid when MemRead=1 and Stall=0
//  Stall           out  1                  combinational; freeze pipeline while high
//  MemAddress      out  32                 registered request address to memory
//  ReadMiss        out  1                  block read request to memory
//  MemWriteThrough out  1                  word write request to memory
//  MemWriteData    out  32                 registered store word to memory
//  MemReadData     in   32*BLOCK_SIZE      returned block; word i at [32i+31:32i]
//  MemReadReady    in   1                  one-cycle pulse: MemReadData valid
//  MemWriteReady   in   1                  one-cycle pulse: write-through done
//  HitCount        out  32                 statistics (see CONFIGURATION)
//  MissCount       out  32                 statistics (see CONFIGURATION)
// BEHAVIOUR
//  Storage:
//  - Per line: valid bit, tag, BLOCK_SIZE-word data.
//  - hit = valid[idx] && tag match.
//  FSM states: IDLE, RD_MISS, WR_THRU, DONE.
//  - IDLE, lw hit:
//    - ReadData = line word, combinational; Stall=0; state unchanged.
//  - IDLE, lw miss:
//    - Stall=1; latch Addr into MemAddress; -> RD_MISS.
//  - IDLE, sw hit:
//    - Stall=1; write WriteData into the line word at the clock edge.
//    - Latch Addr and WriteData; -> WR_THRU.
//  - IDLE, sw miss:
//    - Stall=1; latch Addr and WriteData; -> RD_MISS with the sw flag set.
//  - RD_MISS:
//    - ReadMiss=1; MemWriteThrough=sw flag; Stall=1.
//    - On MemReadReady: install MemReadData, tag, valid=1; clear the sw flag; -> DONE.
//    - sw miss merge: install the returned block with word[Addr[3:2]] replaced by the latched
//      store data. Memory returns the block as it was before the write.
//  - WR_THRU:
//    - MemWriteThrough=1; Stall=1.
//    - On MemWriteReady: -> DONE.
//  - DONE:
//    - Stall=0; ReadData from the now-valid line.
//    - No new request is accepted in this cycle; the pipeline advances at the next edge. -> IDLE.
//  Request and ready rules:
//  - ReadMiss and MemWriteThrough are decoded from the registered state only, never
//    combinationally from the CPU inputs.
//  - Both drop at the edge that consumes the ready pulse.
//  - MemAddress and MemWriteData stay stable for the whole request.
//  - A ready pulse not matching the current state (e.g. MemWriteReady in RD_MISS) is ignored.
//  - A request with MemRead=MemWrite=0 causes no action.
//  Eviction: the line is overwritten without writeback (write-through keeps memory current).
//  Reset (asynchronous, also mid-miss):
//  - state=IDLE; all valid bits=0; sw flag=0.
//  - MemAddress=0, MemWriteData=0, ReadMiss=0, MemWriteThrough=0.
//  - ReadData=0, Stall=0, HitCount=0, MissCount=0.
//  - Data and tag arrays are not cleared.
//  - An in-flight request is abandoned and late ready pulses are ignored.
// CONFIGURATION
//  DCACHE_STATS_EN
//  - Defined:
//    - HitCount +1 on every IDLE hit, counted once per access.
//    - MissCount +1 on every IDLE->RD_MISS transition.
//    - 32-bit counters; wrap 0xFFFFFFFF -> 0.
//  - Undefined: HitCount and MissCount tied to 0; no counter flops synthesized.
// TESTING
//  1. Mem[0x40..0x4C]=1,2,3,4; lw 0x48 cold -> Stall high until the cycle after
//     MemReadReady, ReadData=3; then lw 0x4C -> hit, Stall=0, ReadData=4.
//  2. sw 0xAA at 0x44 (line 0x40 valid) -> MemWriteThrough=1, MemAddress=0x44 until
//     MemWriteReady; lw 0x44 -> hit, ReadData=0xAA.
//  3. sw 0x55 at 0x88 cold (Mem[0x88]=7) -> ReadMiss=MemWriteThrough=1; line installs
//     0x55, not 7; lw 0x88 hit=0x55; MissCount=1 with STATS_EN.
//  4. lw 0x40, then lw 0xC0 (same index, SETS=8) -> second access misses and evicts;
//     lw 0x40 misses again.
//  5. Rst pulsed 5 cycles into an RD_MISS -> ReadMiss=0 and Stall=0 immediately; the late
//     MemReadReady is ignored; lw 0x40 misses.
//  6. MemRead=MemWrite=1 at 0x50 -> handled as sw; only MemWriteThrough/ReadMiss per the sw rules.

Source files
------------

// File: rtl/data_cache_if.sv
// Bus bundle between the MEM stage / data memory and the L1 data cache.
interface data_cache_if #(
   parameter int unsigned BLOCK_SIZE = 4
) ();

   // CPU (MEM stage) side
   logic                       MemRead;
   logic                       MemWrite;
   logic [31:0]                Addr;
   logic [31:0]                WriteData;
   logic [31:0]                ReadData;
   logic                       Stall;

   // Data memory side
   logic [31:0]                MemAddress;
   logic                       ReadMiss;
   logic                       MemWriteThrough;
   logic [31:0]                MemWriteData;
   logic [32*BLOCK_SIZE-1:0]   MemReadData;
   logic                       MemReadReady;
   logic                       MemWriteReady;

   // Statistics
   logic [31:0]                HitCount;
   logic [31:0]                MissCount;

   // Cache view
   modport slave (
      input  MemRead, MemWrite, Addr, WriteData,
      input  MemReadData, MemReadReady, MemWriteReady,
      output ReadData, Stall,
      output MemAddress, ReadMiss, MemWriteThrough, MemWriteData,
      output HitCount, MissCount
   );

   // Pipeline + memory view
   modport master (
      output MemRead, MemWrite, Addr, WriteData,
      output MemReadData, MemReadReady, MemWriteReady,
      input  ReadData, Stall,
      input  MemAddress, ReadMiss, MemWriteThrough, MemWriteData,
      input  HitCount, MissCount
   );

endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined;
// otherwise HitCount/MissCount read as zero and no counter flops exist.
module data_cache #(
   parameter int unsigned SETS       = 8,
   parameter int unsigned INDEX_BITS = 3,
   parameter int unsigned BLOCK_SIZE = 4
) (
   input logic         Clk,
   input logic         Rst,
   data_cache_if.slave bus
);

   localparam int unsigned OFF_BITS = $clog2(BLOCK_SIZE);
   localparam int unsigned IDX_LSB  = 2 + OFF_BITS;
   localparam int unsigned TAG_LSB  = IDX_LSB + INDEX_BITS;
   localparam int unsigned TAG_BITS = 32 - TAG_LSB;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_MISS = 2'd1,
      S_WR_THRU = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;

   logic [SETS-1:0]         r_valid;
   logic [TAG_BITS-1:0]     r_tag  [SETS];
   logic [31:0]             r_data [SETS][BLOCK_SIZE];

   logic                    r_sw_flag;
   logic [31:0]             r_mem_addr;
   logic [31:0]             r_mem_wdata;

   logic [INDEX_BITS-1:0]   w_req_idx;
   logic [OFF_BITS-1:0]     w_req_off;
   logic [TAG_BITS-1:0]     w_req_tag;
   logic [INDEX_BITS-1:0]   w_mem_idx;
   logic [OFF_BITS-1:0]     w_mem_off;
   logic [TAG_BITS-1:0]     w_mem_tag;
   logic                    w_hit;

   logic                    w_stall;
   logic [31:0]             w_read_data;
   logic                    w_latch;
   logic                    w_set_sw;
   logic                    w_hit_wr;
   logic                    w_install;
   logic                    w_count_hit;
   logic                    w_count_miss;
   logic                    w_unused_addr;

   // Address field decode for the incoming request and the latched request
   assign w_req_idx = bus.Addr[IDX_LSB +: INDEX_BITS];
   assign w_req_off = bus.Addr[2 +: OFF_BITS];
   assign w_req_tag = bus.Addr[TAG_LSB +: TAG_BITS];
   assign w_mem_idx = r_mem_addr[IDX_LSB +: INDEX_BITS];
   assign w_mem_off = r_mem_addr[2 +: OFF_BITS];
   assign w_mem_tag = r_mem_addr[TAG_LSB +: TAG_BITS];
   assign w_hit     = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

   // Byte-within-word bits carry no meaning for word accesses
   assign w_unused_addr = ^bus.Addr[1:0];

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next state, stall/read data and array/latch enables; all quiet while in reset
   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      w_read_data  = 32'd0;
      w_latch      = 1'b0;
      w_set_sw     = 1'b0;
      w_hit_wr     = 1'b0;
      w_install    = 1'b0;
      w_count_hit  = 1'b0;
      w_count_miss = 1'b0;
      if (!Rst) begin
         case (r_state)
            S_IDLE: begin
               if (bus.MemWrite) begin
                  w_stall = 1'b1;
                  w_latch = 1'b1;
                  if (w_hit) begin
                     w_hit_wr     = 1'b1;
                     w_count_hit  = 1'b1;
                     w_next_state = S_WR_THRU;
                  end else begin
                     w_set_sw     = 1'b1;
                     w_count_miss = 1'b1;
                     w_next_state = S_RD_MISS;
                  end
               end else if (bus.MemRead) begin
                  if (w_hit) begin
                     w_read_data = r_data[w_req_idx][w_req_off];
                     w_count_hit = 1'b1;
                  end else begin
                     w_stall      = 1'b1;
                     w_latch      = 1'b1;
                     w_count_miss = 1'b1;
                     w_next_state = S_RD_MISS;
                  end
               end
            end
            S_RD_MISS: begin
               w_stall = 1'b1;
               if (bus.MemReadReady) begin
                  w_install    = 1'b1;
                  w_next_state = S_DONE;
               end
            end
            S_WR_THRU: begin
               w_stall = 1'b1;
               if (bus.MemWriteReady) w_next_state = S_DONE;
            end
            S_DONE: begin
               w_read_data  = r_data[w_mem_idx][w_mem_off];
               w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // Valid bits, pending-store flag and the latched memory request
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_valid     <= '0;
         r_sw_flag   <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
      end else begin
         if (w_latch) r_mem_addr <= bus.Addr;
         if (w_latch && bus.MemWrite) r_mem_wdata <= bus.WriteData;
         if (w_set_sw) r_sw_flag <= 1'b1;
         if (w_install) begin
            r_valid[w_mem_idx] <= 1'b1;
            r_sw_flag          <= 1'b0;
         end
      end
   end

   // Tag/data arrays: store hits update one word; fills merge a pending store word
   always_ff @(posedge Clk) begin
      if (w_hit_wr) r_data[w_req_idx][w_req_off] <= bus.WriteData;
      if (w_install) begin
         r_tag[w_mem_idx] <= w_mem_tag;
         for (int unsigned w = 0; w < BLOCK_SIZE; w++) begin
            if (r_sw_flag && (OFF_BITS'(w) == w_mem_off))
               r_data[w_mem_idx][OFF_BITS'(w)] <= r_mem_wdata;
            else
               r_data[w_mem_idx][OFF_BITS'(w)] <= bus.MemReadData[32*w +: 32];
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   // Free-running wrap-around access statistics
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_hit_count  <= 32'd0;
         r_miss_count <= 32'd0;
      end else begin
         if (w_count_hit)  r_hit_count  <= r_hit_count + 32'd1;
         if (w_count_miss) r_miss_count <= r_miss_count + 32'd1;
      end
   end

   assign bus.HitCount  = r_hit_count;
   assign bus.MissCount = r_miss_count;
`else
   logic w_unused_stats;
   assign w_unused_stats = w_count_hit ^ w_count_miss;
   assign bus.HitCount   = 32'd0;
   assign bus.MissCount  = 32'd0;
`endif

   // Memory requests come straight from the registered state
   assign bus.ReadMiss        = (r_state == S_RD_MISS);
   assign bus.MemWriteThrough = (r_state == S_WR_THRU) || ((r_state == S_RD_MISS) && r_sw_flag);
   assign bus.MemAddress      = r_mem_addr;
   assign bus.MemWriteData    = r_mem_wdata;
   assign bus.Stall           = w_stall;
   assign bus.ReadData        = w_read_data;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random lw/sw traffic
// checked against a word-addressed memory model and a line-residency model.
module tb_data_cache;

   logic Clk;
   logic Rst;

   data_cache_if #(.BLOCK_SIZE(4)) bus ();

   data_cache #(.SETS(8), .INDEX_BITS(3), .BLOCK_SIZE(4)) u_dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Reference state: backing memory, which block each set holds, statistics
   logic [31:0] mem_model [logic [29:0]];
   bit          res_valid [8];
   logic [27:0] res_blk   [8];
   int unsigned exp_hits;
   int unsigned exp_misses;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
      return {2'b00, a[31:2]} ^ 32'hA5A5_0000;
   endfunction

   task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
      mem_model[a[31:2]] = d;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) res_valid[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
      check({tag, "_hitcnt"},  bus.HitCount,  exp_hits);
      check({tag, "_misscnt"}, bus.MissCount, exp_misses);
`else
      check({tag, "_hitcnt"},  bus.HitCount,  32'd0);
      check({tag, "_misscnt"}, bus.MissCount, 32'd0);
`endif
   endtask

   // One CPU access; the bench also plays data memory with latency lat.
   // spur drives the ready pulse that does not belong to the current request.
   task automatic access(input string tag, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input bit spur);
      bit          hit;
      int          idx;
      int          n;
      int          wc;
      int          exp_n;
      logic [27:0] blk;
      idx   = int'(a[6:4]);
      blk   = a[31:4];
      hit   = res_valid[idx] && (res_blk[idx] == blk);
      exp_n = (wr || (rd && !hit)) ? lat + 1 : 0;
      @(negedge Clk);
      check_stats(tag);
      bus.MemRead   = rd;
      bus.MemWrite  = wr;
      bus.Addr      = a;
      bus.WriteData = wd;
      #1;
      n  = 0;
      wc = 0;
      while (bus.Stall === 1'b1 && n < 200) begin
         bus.MemReadReady  = 1'b0;
         bus.MemWriteReady = 1'b0;
         if (bus.ReadMiss === 1'b1 || bus.MemWriteThrough === 1'b1) begin
            wc++;
            if (wc == lat) begin
               check({tag, "_readmiss"}, 32'(bus.ReadMiss), 32'(!hit));
               check({tag, "_wthru"}, 32'(bus.MemWriteThrough), 32'(wr));
               check({tag, "_memaddr"}, bus.MemAddress, a);
               if (wr) check({tag, "_memwdata"}, bus.MemWriteData, wd);
               if (bus.ReadMiss === 1'b1) begin
                  for (int w = 0; w < 4; w++)
                     bus.MemReadData[32*w +: 32] = mem_rd({bus.MemAddress[31:4], 4'(w * 4)});
                  bus.MemReadReady = 1'b1;
               end else begin
                  bus.MemWriteReady = 1'b1;
               end
               if (bus.MemWriteThrough === 1'b1) mem_wr(bus.MemAddress, bus.MemWriteData);
            end else if (spur) begin
               if (bus.ReadMiss === 1'b1) begin
                  bus.MemWriteReady = 1'b1;
               end else begin
                  bus.MemReadData  = {4{32'hDEAD_BEEF}};
                  bus.MemReadReady = 1'b1;
               end
            end
         end
         @(negedge Clk);
         #1;
         n++;
      end
      bus.MemReadReady  = 1'b0;
      bus.MemWriteReady = 1'b0;
      check({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
      check({tag, "_req_drop"}, {30'd0, bus.ReadMiss, bus.MemWriteThrough}, 32'd0);
      if (rd && !wr) check({tag, "_rdata"}, bus.ReadData, mem_rd(a));
      if (rd || wr) begin
         if (hit) exp_hits++;
         else     exp_misses++;
         res_valid[idx] = 1'b1;
         res_blk[idx]   = blk;
      end
   endtask

   initial begin
      logic [31:0] a;
      int          op;
      bus.MemRead       = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.Addr          = 32'd0;
      bus.WriteData     = 32'd0;
      bus.MemReadData   = '0;
      bus.MemReadReady  = 1'b0;
      bus.MemWriteReady = 1'b0;
      model_reset();
      Rst = 1'b1;
      #1;
      check("rst_readmiss", 32'(bus.ReadMiss), 32'd0);
      check("rst_wthru",    32'(bus.MemWriteThrough), 32'd0);
      check("rst_stall",    32'(bus.Stall), 32'd0);
      check("rst_memaddr",  bus.MemAddress, 32'd0);
      check("rst_memwdata", bus.MemWriteData, 32'd0);
      check("rst_rdata",    bus.ReadData, 32'd0);
      check("rst_hitcnt",   bus.HitCount, 32'd0);
      check("rst_misscnt",  bus.MissCount, 32'd0);
      repeat (2) @(negedge Clk);
      Rst = 1'b0;

      mem_wr(32'h40, 32'd1);
      mem_wr(32'h44, 32'd2);
      mem_wr(32'h48, 32'd3);
      mem_wr(32'h4C, 32'd4);
      mem_wr(32'h88, 32'd7);

      // Cold read miss then hit in the same line
      access("t1_lw48", 1'b1, 1'b0, 32'h48, 32'd0, 3, 1'b0);
      access("t1_lw4c", 1'b1, 1'b0, 32'h4C, 32'd0, 2, 1'b0);
      // Store hit with write-through; stray MemReadReady ignored
      access("t2_sw44", 1'b0, 1'b1, 32'h44, 32'hAA, 3, 1'b1);
      access("t2_lw44", 1'b1, 1'b0, 32'h44, 32'd0, 1, 1'b0);
      // Store miss: allocate and merge store word over returned block
      access("t3_sw88", 1'b0, 1'b1, 32'h88, 32'h55, 3, 1'b1);
      access("t3_lw88", 1'b1, 1'b0, 32'h88, 32'd0, 1, 1'b0);
      // Conflict eviction in set 4
      access("t4_lw40a", 1'b1, 1'b0, 32'h40, 32'd0, 1, 1'b0);
      access("t4_lwc0",  1'b1, 1'b0, 32'hC0, 32'd0, 4, 1'b1);
      access("t4_lw40b", 1'b1, 1'b0, 32'h40, 32'd0, 2, 1'b0);
      // MemRead and MemWrite together behave as a store
      access("t6_rw50", 1'b1, 1'b1, 32'h50, 32'h1234, 2, 1'b0);
      access("t6_lw50", 1'b1, 1'b0, 32'h50, 32'd0, 1, 1'b0);

      // Reset in the middle of a read miss; the late fill must be dropped
      @(negedge Clk);
      bus.MemRead  = 1'b1;
      bus.MemWrite = 1'b0;
      bus.Addr     = 32'h100;
      repeat (5) @(negedge Clk);
      #1;
      check("t5_readmiss_pre", 32'(bus.ReadMiss), 32'd1);
      check("t5_stall_pre",    32'(bus.Stall), 32'd1);
      Rst = 1'b1;
      #1;
      check("t5_readmiss_rst", 32'(bus.ReadMiss), 32'd0);
      check("t5_stall_rst",    32'(bus.Stall), 32'd0);
      check("t5_memaddr_rst",  bus.MemAddress, 32'd0);
      @(negedge Clk);
      Rst         = 1'b0;
      bus.MemRead = 1'b0;
      model_reset();
      @(negedge Clk);
      bus.MemReadData  = {4{32'hBAD0_BAD0}};
      bus.MemReadReady = 1'b1;
      @(negedge Clk);
      bus.MemReadReady = 1'b0;
      #1;
      check("t5_readmiss_late", 32'(bus.ReadMiss), 32'd0);
      check("t5_stall_late",    32'(bus.Stall), 32'd0);
      access("t5_lw40", 1'b1, 1'b0, 32'h40, 32'd0, 2, 1'b0);

      // Random traffic over a few tags and sets to force hits, misses, evictions
      for (int k = 0; k < 60; k++) begin
         a  = 32'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 4) |
                  ($urandom_range(0, 3) << 2));
         op = int'($urandom_range(0, 7));
         access("rnd", (op >= 1 && op <= 3) || op == 7, op >= 4, a, $urandom(),
                int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
      end

      @(negedge Clk);
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      check_stats("final");
      @(negedge Clk);
      #1;
      check("final_stall", 32'(bus.Stall), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
